alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle core ALU.
- Sits between decode and LSU/MEM/fetch.
- Accepts one operation per valid/ready transfer and returns a registered result with a valid/ready handshake.
- Single-cycle ops complete with latency 1; an optional iterative multiplier adds a multi-cycle MUL op.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8, power of 2).
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from operand B.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- alu_valid_ip  input  1  request valid from decode.
- alu_ready_op  output  1  ALU can accept a request this cycle.
- alu_operator_ip  input  alu_opcode_e  operation select.
- alu_operand_a_ip  input  WIDTH  operand A.
- alu_operand_b_ip  input  WIDTH  operand B.
- alu_result_op  output  WIDTH  registered result.
- alu_illegal_op  output  1  result belongs to an unsupported opcode.
- alu_valid_op  output  1  result valid.
- alu_ready_ip  input  1  consumer accepts the result.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: alu_valid_op=0, alu_result_op=0, alu_illegal_op=0, FSM=IDLE, multiplier state cleared.
- Reset mid-MUL aborts the operation; no result is produced.
- Input transfer: occurs when alu_valid_ip && alu_ready_op.
- Output transfer: occurs when alu_valid_op && alu_ready_ip.
- alu_ready_op = (state==IDLE) && (!alu_valid_op || alu_ready_ip). Back-to-back single-cycle ops therefore sustain 1 op/cycle while the consumer is ready.
- Result stability: while alu_valid_op=1 and alu_ready_ip=0, result and illegal flag hold stable.
- Operations (all arithmetic modulo 2^WIDTH):
  - ADD: a+b.
  - SUB: a-b.
  - ADDR: a + (b<<1), with the shift in WIDTH bits.
  - SLTS: signed a<b, using a true signed compare that is correct on overflow (e.g. a=0x80000000, b=1 gives 1). Result is zero-extended.
  - SLTU: unsigned a<b.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift amount is b[SHAMT_W-1:0].
- Single-cycle ops: result is registered at the accepting edge; alu_valid_op=1 on the next cycle (latency 1).
- Illegal/unsupported opcode: accepted normally; result=0, alu_illegal_op=1, alu_valid_op=1 next cycle. The ALU never drops a request.
- FSM:
  - IDLE: accept requests. Single-cycle op → result register loaded, stay in IDLE. MUL (feature enabled) → BUSY.
  - BUSY: one shift-add step per cycle for WIDTH cycles, counter 0..WIDTH-1. alu_ready_op=0.
  - BUSY → DONE when counter==WIDTH-1. Low WIDTH bits of the product go to the result register; alu_valid_op=1.
  - DONE: hold until the output transfer, then → IDLE. No new request is accepted in the same cycle as leaving DONE.
  - MUL latency: WIDTH+1 cycles from acceptance to alu_valid_op.
- Simultaneous output transfer and new input transfer in IDLE: the new result replaces the old one on the same edge; alu_valid_op stays 1.

Optional Feature:
- ALU_MUL_EN defined: ALU_MUL op supported via the alu_mul_iter FSM path (BUSY/DONE states present).
- ALU_MUL_EN undefined: no multiplier logic; the FSM reduces to IDLE only. ALU_MUL is treated as an illegal opcode (result 0, alu_illegal_op=1, latency 1).

Decomposition:
- CORE_PKG: extend alu_opcode_e with ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL.
- CORE_PKG: add alu_state_e {IDLE, BUSY, DONE}.
- CORE_PKG: add an ALU_WIDTH_DEF=32 constant.
- Sub-module alu_mul_iter (WIDTH):
  - Inputs: start, a, b.
  - Outputs: done pulse, product low WIDTH bits.
  - Counter and shift-add datapath.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset held 2 cycles mid-traffic → alu_valid_op=0, alu_result_op=0, alu_ready_op=1 on the first cycle after reset deasserts.
- Back-to-back ADD 5+7, SUB 3-5, SLTS 0x80000000,1, alu_ready_ip=1 → results 12, 0xFFFFFFFE, 1 on consecutive cycles, 1 op/cycle.
- ADDR a=0x1000, b=0x80000001; SRA 0x80000000 by b=0x24 (shamt 4) → 0x1002, then 0xF8000000.
- Backpressure: XOR 0xFF00FF00^0x0F0F0F0F with alu_ready_ip=0 for 3 cycles → result 0xF00FF00F held stable, alu_ready_op=0 until release.
- ALU_MUL_EN: MUL 0xFFFF×0x10001 → 0xFFFFFFFF after 33 cycles, alu_ready_op=0 while BUSY. Reset at cycle 10 of the MUL → no result, back to IDLE.
- Undefined opcode, and ALU_MUL with ALU_MUL_EN undefined → alu_illegal_op=1, result 0, latency 1.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the core ALU: opcode encoding, pipeline FSM states and
// the default datapath width.
package alu_pipe_pkg;

   localparam int ALU_WIDTH_DEF = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_ADDR = 4'd2,
      ALU_SLTS = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_MUL  = 4'd11
   } alu_opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH
// cycles after start, then a one-cycle done pulse with the low WIDTH bits of
// the product. The module body only exists when ALU_MUL_EN is defined, so a
// default build carries no multiplier at all.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;

   // Load operands on start, then add the shifted multiplicand per set bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
         end else if (busy) begin
            if (b_sh[0]) acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = acc;

endmodule
`endif

// File: rtl/alu_pipe.sv
// Handshaked core ALU with a registered result. Single-cycle ops have
// latency 1; defining ALU_MUL_EN adds an iterative multi-cycle ALU_MUL.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH_DEF,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid_ip,
   output logic             alu_ready_op,
   input  alu_opcode_e      alu_operator_ip,
   input  logic [WIDTH-1:0] alu_operand_a_ip,
   input  logic [WIDTH-1:0] alu_operand_b_ip,
   output logic [WIDTH-1:0] alu_result_op,
   output logic             alu_illegal_op,
   output logic             alu_valid_op,
   input  logic             alu_ready_ip
);

   alu_state_e       state_q;
   logic             accept;
   logic             out_xfer;
   logic             mul_req;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] calc_result;
   logic             calc_illegal;
   logic [SHAMT_W-1:0] shamt;

   assign alu_ready_op = (state_q == IDLE) && (!alu_valid_op || alu_ready_ip);
   assign accept       = alu_valid_ip && alu_ready_op;
   assign out_xfer     = alu_valid_op && alu_ready_ip;
   assign shamt        = alu_operand_b_ip[SHAMT_W-1:0];

`ifdef ALU_MUL_EN
   assign mul_req = (alu_operator_ip == ALU_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && mul_req),
      .a       (alu_operand_a_ip),
      .b       (alu_operand_b_ip),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign mul_req     = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // Single-cycle result; anything not decoded here is flagged illegal.
   always_comb begin
      calc_result  = '0;
      calc_illegal = 1'b0;
      case (alu_operator_ip)
         ALU_ADD:  calc_result = alu_operand_a_ip + alu_operand_b_ip;
         ALU_SUB:  calc_result = alu_operand_a_ip - alu_operand_b_ip;
         ALU_ADDR: calc_result = alu_operand_a_ip + (alu_operand_b_ip << 1);
         ALU_SLTS: calc_result = {{(WIDTH-1){1'b0}},
                                  ($signed(alu_operand_a_ip) < $signed(alu_operand_b_ip))};
         ALU_SLTU: calc_result = {{(WIDTH-1){1'b0}}, (alu_operand_a_ip < alu_operand_b_ip)};
         ALU_AND:  calc_result = alu_operand_a_ip & alu_operand_b_ip;
         ALU_OR:   calc_result = alu_operand_a_ip | alu_operand_b_ip;
         ALU_XOR:  calc_result = alu_operand_a_ip ^ alu_operand_b_ip;
         ALU_SLL:  calc_result = alu_operand_a_ip << shamt;
         ALU_SRL:  calc_result = alu_operand_a_ip >> shamt;
         ALU_SRA:  calc_result = $signed(alu_operand_a_ip) >>> shamt;
`ifdef ALU_MUL_EN
         ALU_MUL:  calc_result = '0;
`endif
         default:  calc_illegal = 1'b1;
      endcase
   end

   // Pipeline FSM and result register; a new accept replaces a result that
   // is leaving on the same edge, so valid stays high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         alu_valid_op   <= 1'b0;
         alu_result_op  <= '0;
         alu_illegal_op <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && mul_req) begin
                  state_q      <= BUSY;
                  alu_valid_op <= 1'b0;
               end else if (accept) begin
                  alu_result_op  <= calc_result;
                  alu_illegal_op <= calc_illegal;
                  alu_valid_op   <= 1'b1;
               end else if (out_xfer) begin
                  alu_valid_op <= 1'b0;
               end
            end
            BUSY: begin
               if (mul_done) begin
                  alu_result_op  <= mul_product;
                  alu_illegal_op <= 1'b0;
                  alu_valid_op   <= 1'b1;
                  state_q        <= DONE;
               end
            end
            DONE: begin
               if (out_xfer) begin
                  alu_valid_op <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: table-driven ops through a scoreboard, plus hand
// sequences for backpressure, reset and (with ALU_MUL_EN) the multiplier.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         alu_valid_ip = 1'b0;
   logic         alu_ready_ip = 1'b1;
   alu_opcode_e  alu_operator_ip = ALU_ADD;
   logic [W-1:0] alu_operand_a_ip = '0;
   logic [W-1:0] alu_operand_b_ip = '0;
   logic         alu_ready_op;
   logic [W-1:0] alu_result_op;
   logic         alu_illegal_op;
   logic         alu_valid_op;

   typedef struct {
      logic [W-1:0] r;
      logic         ill;
   } exp_t;

   typedef struct {
      alu_opcode_e  op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         ill;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[$];
   int unsigned passed = 0;
   int unsigned total  = 0;

   alu_pipe #(.WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .alu_valid_ip     (alu_valid_ip),
      .alu_ready_op     (alu_ready_op),
      .alu_operator_ip  (alu_operator_ip),
      .alu_operand_a_ip (alu_operand_a_ip),
      .alu_operand_b_ip (alu_operand_b_ip),
      .alu_result_op    (alu_result_op),
      .alu_illegal_op   (alu_illegal_op),
      .alu_valid_op     (alu_valid_op),
      .alu_ready_ip     (alu_ready_ip)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one request until accepted; expected result queued at acceptance.
   task automatic send(input alu_opcode_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic ill, output int stalls);
      alu_operator_ip  = o;
      alu_operand_a_ip = a;
      alu_operand_b_ip = b;
      alu_valid_ip     = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (!alu_ready_op && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      if (!alu_ready_op) begin
         total++;
         $display("FAIL accept_timeout: op %0d never accepted", o);
         alu_valid_ip = 1'b0;
      end else begin
         sb.push_back('{r: r, ill: ill});
         @(posedge clk);
         #1 alu_valid_ip = 1'b0;
      end
   endtask

   // Compare each result on the cycle its output transfer happens.
   always @(negedge clk) begin
      if (!reset && alu_valid_op && alu_ready_ip) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: got %h with no pending request", alu_result_op);
         end else begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (alu_result_op === e.r && alu_illegal_op === e.ill) passed++;
            else $display("FAIL result: got %h/ill=%b expected %h/ill=%b",
                          alu_result_op, alu_illegal_op, e.r, e.ill);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      int stall_sum;
      int n;
      logic seen;

      vecs.push_back('{ALU_ADD,  32'd5,          32'd7,          32'd12,         1'b0});
      vecs.push_back('{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0});
      vecs.push_back('{ALU_SLTS, 32'h8000_0000,  32'd1,          32'd1,          1'b0});
      vecs.push_back('{ALU_ADDR, 32'h0000_1000,  32'h8000_0001,  32'h0000_1002,  1'b0});
      vecs.push_back('{ALU_SRA,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000,  1'b0});
      vecs.push_back('{ALU_SLTS, 32'd1,          32'h8000_0000,  32'd0,          1'b0});
      vecs.push_back('{ALU_SLTU, 32'd1,          32'h8000_0000,  32'd1,          1'b0});
      vecs.push_back('{ALU_SLTU, 32'd5,          32'd5,          32'd0,          1'b0});
      vecs.push_back('{ALU_AND,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0});
      vecs.push_back('{ALU_OR,   32'hFF00_FF00,  32'h0F0F_0F0F,  32'hFF0F_FF0F,  1'b0});
      vecs.push_back('{ALU_XOR,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F,  1'b0});
      vecs.push_back('{ALU_SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0});
      vecs.push_back('{ALU_SRL,  32'h8000_0000,  32'h0000_0021,  32'h4000_0000,  1'b0});
      vecs.push_back('{ALU_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
      vecs.push_back('{alu_opcode_e'(4'hF), 32'd9, 32'd9,         32'd0,          1'b1});
`ifndef ALU_MUL_EN
      vecs.push_back('{ALU_MUL,  32'h0000_FFFF,  32'h0001_0001,  32'd0,          1'b1});
`endif

      // Reset state.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_valid", alu_valid_op, 0);
      check("reset_result", alu_result_op, 0);
      check("reset_illegal", alu_illegal_op, 0);
      check("reset_ready", alu_ready_op, 1);

      // Back-to-back table run with the consumer always ready.
      @(posedge clk);
      #1;
      stall_sum = 0;
      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].ill, stalls);
         stall_sum += stalls;
      end
      check("throughput_stalls", stall_sum, 0);

      // Illegal opcode: result visible one cycle after acceptance.
      send(alu_opcode_e'(4'hE), 32'h1234, 32'h5678, 32'd0, 1'b1, stalls);
      check("illegal_lat1_valid", alu_valid_op, 1);
      check("illegal_lat1_flag", alu_illegal_op, 1);
      check("illegal_lat1_result", alu_result_op, 0);

      // Backpressure: result holds and no new request is accepted.
      @(posedge clk);
      #1 alu_ready_ip = 1'b0;
      send(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, stalls);
      for (int unsigned k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_valid", alu_valid_op, 1);
         check("bp_result", alu_result_op, 32'hF00F_F00F);
         check("bp_ready", alu_ready_op, 0);
      end
      @(posedge clk);
      #1 alu_ready_ip = 1'b1;
      @(posedge clk);
      #1 check("bp_drained_valid", alu_valid_op, 0);

      // Reset mid-traffic: pending result and pending request discarded.
      alu_ready_ip = 1'b0;
      send(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, stalls);
      alu_operator_ip  = ALU_SUB;
      alu_operand_a_ip = 32'd9;
      alu_operand_b_ip = 32'd4;
      alu_valid_ip     = 1'b1;
      reset = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset        = 1'b0;
      alu_valid_ip = 1'b0;
      alu_ready_ip = 1'b1;
      @(negedge clk);
      check("midreset_valid", alu_valid_op, 0);
      check("midreset_result", alu_result_op, 0);
      check("midreset_ready", alu_ready_op, 1);

`ifdef ALU_MUL_EN
      // Multiplier: WIDTH+1 cycle latency, not ready while busy.
      @(posedge clk);
      #1;
      send(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, stalls);
      n = 0;
      seen = 1'b0;
      while (!alu_valid_op && n < 40) begin
         if (alu_ready_op) seen = 1'b1;
         @(posedge clk);
         #1 n++;
      end
      check("mul_latency", n, 33);
      check("mul_busy_ready", seen, 0);
      @(posedge clk);
      #1;

      // Reset ten cycles into a multiply: no result afterwards.
      send(ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b0, stalls);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (alu_valid_op) seen = 1'b1;
      end
      check("mul_abort_no_result", seen, 0);
      check("mul_abort_ready", alu_ready_op, 1);
`endif

      // Drain the scoreboard.
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
